// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   md_op_e        4-bit MD operation encoding seen in the E stage
//   *_CYCLES_DEF   default busy latencies for multiply and divide
//   is_md_start()  true for the four ops that launch an arithmetic run
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath.
//   op   in  4   operation (only MULT/MULTU/DIV/DIVU produce a result)
//   rs   in  32  first operand (multiplicand / dividend)
//   rt   in  32  second operand (multiplier / divisor)
//   res  out 64  {hi, lo}: product, or {remainder, quotient}
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] abs_a;
  logic        [31:0] abs_b;
  logic        [31:0] mag_q;
  logic        [31:0] mag_r;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic        [31:0] sq;
  logic        [31:0] sr;

  always_comb begin
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide works on magnitudes, then restores signs: the quotient
    // is negative when operand signs differ, the remainder follows the dividend.
    abs_a = rs[31] ? -rs : rs;
    abs_b = rt[31] ? -rt : rt;
    mag_q = '0;
    mag_r = '0;
    if (abs_b != '0) begin
      mag_q = abs_a / abs_b;
      mag_r = abs_a % abs_b;
    end
    sq = (rs[31] ^ rt[31]) ? -mag_q : mag_q;
    sr = rs[31] ? -mag_r : mag_r;

    if (rt == '0) begin
      sq = '1;
      sr = rs;
    end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
      sq = 32'h8000_0000;
      sr = '0;
    end

    if (rt == '0) begin
      uq = '1;
      ur = rs;
    end else begin
      uq = rs / rt;
      ur = rs % rt;
    end

    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {sr, sq};
      MD_DIVU:  res = {ur, uq};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller owning HI/LO.
//   clk, reset    clock and asynchronous active-high reset
//   md_op_E       E-stage MD operation (mdu_pkg::md_op_e encoding)
//   rs_E, rt_E    forwarded operands in E
//   md_use_D      the D-stage instruction is an MD instruction
//   busy          an arithmetic operation is in flight
//   stall_md      hold F/D and bubble D/E while an MD op in D must wait
//   hi, lo        architectural HI/LO
//   md_out        HI for MFHI, LO for MFLO, else 0
// The result is computed at start and parked in pend_hi/pend_lo; it only
// becomes architectural after the modelled latency has elapsed.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] arith_res;
  logic        start;
  logic        is_mult;

  mdu_arith u_arith (
    .op  (md_op_E),
    .rs  (rs_E),
    .rt  (rt_E),
    .res (arith_res)
  );

  assign start   = (state_q == ST_IDLE) && is_md_start(md_op_E);
  assign is_mult = (md_op_E == MD_MULT) || (md_op_E == MD_MULTU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_hi_d = arith_res[63:32];
          pend_lo_d = arith_res[31:0];
          cnt_d     = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_d   = ST_RUN;
        end else if (md_op_E == MD_MTHI) begin
          hi_d = rs_E;
        end else if (md_op_E == MD_MTLO) begin
          lo_d = rs_E;
        end
      end
      ST_RUN: begin
        // Any op presented in RUN is a protocol violation and is ignored.
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  // Stall covers the start cycle itself so a dependent MD op never enters E
  // alongside the op that launches the run.
  assign stall_md = md_use_D && (start || busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    md_out = '0;
    if (md_op_E == MD_MFHI) md_out = hi_q;
    else if (md_op_E == MD_MFLO) md_out = lo_q;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage pipeline. It accepts an MD operation from the E stage and owns the HI/LO registers. It sequences the fixed-latency multiply or divide and generates `stall_md`, which holds F/D and bubbles the D/E pipeline register while a following MD instruction must wait.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- `clk`  in  1: the one clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `md_op_E`  in  4: E-stage MD operation, encoded per `mdu_pkg`: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- `rs_E`  in  32: forwarded rs operand in E.
- `rt_E`  in  32: forwarded rt operand in E.
- `md_use_D`  in  1: the D-stage instruction is any MD instruction (mult/div/mf/mt).
- `busy`  out  1: an operation is in flight; reset 0.
- `stall_md`  out  1: stall request to the hazard path and the D/E register; reset 0.
- `hi`  out  32: architectural HI; reset 0.
- `lo`  out  32: architectural LO; reset 0.
- `md_out`  out  32: `hi` for MFHI, `lo` for MFLO, else 0; combinational.

## Operation
- States: IDLE and RUN. The 4-bit down-counter `cnt` resets to 0. Two 32-bit pending registers, `pend_hi` and `pend_lo`, reset to 0.
- Start condition: `start = state==IDLE && md_op_E ∈ {MULT,MULTU,DIV,DIVU}`.
- On a start edge:
  - Compute the result from `rs_E` and `rt_E` and latch it into `pend_hi` and `pend_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- Arithmetic:
  - MULT: signed 32×32 to 64; `pend_hi` = [63:32], `pend_lo` = [31:0].
  - MULTU: the same, unsigned.
  - DIV and DIVU: `pend_lo` = quotient, `pend_hi` = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (signed or unsigned): quotient 32'hFFFFFFFF, remainder = `rs_E`.
  - Signed overflow (32'h80000000 / −1): quotient 32'h80000000, remainder 0.
- RUN behaviour:
  - Each edge decrements `cnt`.
  - On the edge where `cnt==1`: `hi`←`pend_hi`, `lo`←`pend_lo`, `cnt`←0, state→IDLE.
- `busy = (state==RUN)`.
- MTHI and MTLO in IDLE: `hi` or `lo` ← `rs_E` at the edge.
- Any `md_op_E` other than NONE while in RUN is a protocol violation. It is ignored and state is unchanged. The bench flags it with an assertion.
- `stall_md = md_use_D && (start || busy)`. This is combinational, with no dependence on `md_op_E` beyond `start`.

## Timing
- Start op in E during cycle k. `busy` is high in cycles k+1 .. k+N, where N is the latency parameter.
- New `hi`/`lo` are visible from cycle k+N+1, when `busy` is 0.
- `stall_md` may be high in cycle k (through `start`) and in cycles k+1..k+N. An MD instruction in D therefore enters E no earlier than cycle k+N+1 and reads committed HI/LO.
- MTHI/MTLO: the value is visible from the next cycle. An MFHI/MFLO in E the following cycle reads it.
- Reset asserted at any point, including mid-RUN: immediately state=IDLE, `cnt`=0, `hi`=`lo`=`pend_hi`=`pend_lo`=0, `busy`=0. The pending result is discarded.
- Back-to-back starts are impossible by construction. A start in cycle k+N+1 is legal.

## Structure
- Package `mdu_pkg` holds:
  - the 4-bit op enum typedef (NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO);
  - the default latency constants;
  - an `is_md_start(op)` function.
- Sub-module `mdu_arith` is purely combinational and computes the 64-bit {hi, lo} for the four arithmetic ops, including the divide-by-zero and overflow rules. `mdu_ctrl` holds all sequential state.

## Test plan
- MULT with `rs_E`=32'hFFFFFFFF, `rt_E`=2 → `busy` high for 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
- MULTU with the same operands → HI=1, LO=32'hFFFFFFFE.
- DIV −7/2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF after 10 busy cycles. DIVU 7/2 → LO=3, HI=1.
- DIVU 5/0 → LO=32'hFFFFFFFF, HI=5. DIV 32'h80000000/32'hFFFFFFFF → LO=32'h80000000, HI=0.
- MULT in E with `md_use_D`=1 (MFLO in D) → `stall_md`=1 for the start cycle plus 5 busy cycles, then 0. MFLO then returns the new LO through `md_out`.
- DIV started, `reset` pulsed at busy cycle 4 → `busy`, `hi` and `lo` all 0 immediately; no commit afterwards. MTHI 32'h1234 afterwards → HI=32'h1234 next cycle.
